// File: rtl/bmem_arbiter.sv
// Boot-memory read-port arbiter: shares one registered-latency read port
// between instruction fetch (I) and the data bus (D). D has priority. A
// requester is never re-granted in its own ack cycle, which makes the two
// requesters alternate. D writes are answered with an error ack, and an I
// fetch can be cancelled while it is in flight.
//
// Handshake: a requester raises req with a stable address (and we for D)
// and keeps them until its one-cycle ack; the arbiter samples the address
// and type only in the grant cycle. fsm_state exposes the FSM for debug.
module bmem_arbiter #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                MEM_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_kill_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_sel_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state;
    logic              owner_d;   // 1: current access belongs to D, 0: to I
    logic              kill_q;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;

    logic arb_phase;
    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;

    assign fsm_state = state;

    // Arbitration and combinational memory strobe/address for the grant cycle.
    // Exclusion uses the registered ack itself: in RESP the owner's ack is
    // high, except after a killed fetch, where no ack is given and I may be
    // granted again straight away.
    always_comb begin
        arb_phase  = (state == ST_IDLE) || (state == ST_RESP);
        i_elig     = i_req_i & ~i_ack_o;
        d_elig     = d_req_i & d_sel_i & ~d_ack_o;
        grant_d    = arb_phase & d_elig;
        grant_i    = arb_phase & i_elig & ~d_elig;
        mem_req_o  = grant_i | (grant_d & ~d_we_i);
        mem_addr_o = addr_q;
        if (grant_d) begin
            mem_addr_o = d_addr_i;
        end else if (grant_i) begin
            mem_addr_o = i_addr_i;
        end
    end

    // Access sequencer: grant -> wait MEM_LAT cycles -> one-cycle registered ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_d   <= 1'b0;
            kill_q    <= 1'b0;
            cnt       <= 3'd0;
            addr_q    <= '0;
            i_ack_o   <= 1'b0;
            i_rdata_o <= NOP_VAL;
            d_ack_o   <= 1'b0;
            d_err_o   <= 1'b0;
            d_rdata_o <= '0;
        end else begin
            i_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
            d_err_o <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (grant_d && d_we_i) begin
                        // Boot memory is read-only: answer next cycle with an error.
                        owner_d   <= 1'b1;
                        kill_q    <= 1'b0;
                        d_ack_o   <= 1'b1;
                        d_err_o   <= 1'b1;
                        d_rdata_o <= '0;
                        state     <= ST_RESP;
                    end else if (mem_req_o) begin
                        owner_d <= grant_d;
                        addr_q  <= mem_addr_o;
                        cnt     <= 3'(MEM_LAT);
                        kill_q  <= grant_i & i_kill_i;
                        state   <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (!owner_d && i_kill_i) begin
                        kill_q <= 1'b1;
                    end
                    if (cnt == 3'd1) begin
                        // Memory data is valid now; a killed fetch still runs
                        // to completion but is silently dropped.
                        state  <= ST_RESP;
                        kill_q <= 1'b0;
                        if (owner_d) begin
                            d_ack_o   <= 1'b1;
                            d_rdata_o <= mem_rdata_i;
                        end else if (!(kill_q || i_kill_i)) begin
                            i_ack_o   <= 1'b1;
                            i_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
